instruction_memory_sync: RTL and testbench

Synchronous, parametrised instruction memory for the fetch stage. It replaces the purely combinational word lookup with:
- a sequential program-load port;
- a valid/ready fetch request channel with one-cycle registered read latency;
- a response channel with backpressure;
- alignment and range checking, with an error flag.

It sits between the PC/fetch logic and the decode stage.

---
 rtl/instruction_memory_sync.sv | 117 +++++++++++
 tb/tb_instruction_memory_sync.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory_sync.sv
// Synchronous instruction memory for the fetch stage.
// Words are written in order through a sequential load port. Fetches use a
// valid/ready request channel and come back one cycle later through a
// response register that honours backpressure. A misaligned or out-of-range
// fetch returns a NOP word with the error flag set.
module instruction_memory_sync #(
    parameter int                    MEM_SIZE   = 16,
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] ERR_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_en,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_full,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] adr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] Instruction,
    output logic                  resp_err
);

    // The pointer needs one extra bit so that "all words loaded" is representable.
    localparam int PTR_W = $clog2(MEM_SIZE) + 1;
    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    // True when the byte address cannot be served: low bits set, or the word
    // index (full address width, upper bits included) lies beyond the array.
    function automatic logic fetch_error(input logic [ADDR_WIDTH-1:0] a);
        logic misaligned;
        logic out_of_range;
        misaligned   = (a[1:0] != 2'b00);
        out_of_range = ({2'b00, a[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(MEM_SIZE));
        return misaligned | out_of_range;
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [MEM_SIZE];
    logic [PTR_W-1:0]      load_ptr_r;
    logic                  resp_valid_r;
    logic                  resp_err_r;
    logic [DATA_WIDTH-1:0] instr_r;

    logic                  load_full_s;
    logic                  load_write_s;
    logic                  req_ready_s;
    logic                  accept_s;
    logic                  fetch_err_s;
    logic [IDX_W-1:0]      rd_idx_s;
    logic [DATA_WIDTH-1:0] rd_word_s;

    // Handshake decode: loading blocks fetching, and a full response register
    // only frees up when the consumer takes its contents this cycle.
    always_comb begin
        load_full_s  = (load_ptr_r == PTR_W'(MEM_SIZE));
        load_write_s = load_en & ~load_full_s & ~reset;
        req_ready_s  = ~load_en & (~resp_valid_r | resp_ready);
        accept_s     = req_valid & req_ready_s;
        fetch_err_s  = fetch_error(adr);
        rd_idx_s     = adr[IDX_W+1:2];
        if (fetch_err_s) begin
            rd_word_s = ERR_INSTR;
        end else begin
            rd_word_s = mem_r[rd_idx_s];
        end
    end

    // Storage array: written only by the load port, never cleared by reset.
    always_ff @(posedge clk) begin
        if (load_write_s) begin
            mem_r[load_ptr_r[IDX_W-1:0]] <= load_data;
        end else begin
            mem_r[load_ptr_r[IDX_W-1:0]] <= mem_r[load_ptr_r[IDX_W-1:0]];
        end
    end

    // Load pointer: advances once per accepted load and saturates at MEM_SIZE.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_ptr_r <= {PTR_W{1'b0}};
        end else if (load_write_s) begin
            load_ptr_r <= load_ptr_r + PTR_W'(1);
        end else begin
            load_ptr_r <= load_ptr_r;
        end
    end

    // Response register: fills on accept, drains when taken, holds under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            instr_r      <= {DATA_WIDTH{1'b0}};
        end else if (accept_s) begin
            resp_valid_r <= 1'b1;
            resp_err_r   <= fetch_err_s;
            instr_r      <= rd_word_s;
        end else if (resp_ready) begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= resp_err_r;
            instr_r      <= instr_r;
        end else begin
            resp_valid_r <= resp_valid_r;
            resp_err_r   <= resp_err_r;
            instr_r      <= instr_r;
        end
    end

    assign load_full   = load_full_s;
    assign req_ready   = req_ready_s;
    assign resp_valid  = resp_valid_r;
    assign resp_err    = resp_err_r;
    assign Instruction = instr_r;

endmodule

// File: tb/tb_instruction_memory_sync.sv
// Bench for instruction_memory_sync: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// behavioural model of the memory and its response register.
module tb_instruction_memory_sync;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_en;
    logic [31:0] load_data;
    logic        load_full;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] adr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] Instruction;
    logic        resp_err;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    instruction_memory_sync dut (
        .clk        (clk),
        .reset      (reset),
        .load_en    (load_en),
        .load_data  (load_data),
        .load_full  (load_full),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .adr        (adr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .Instruction(Instruction),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [16];
    int          m_count;
    logic        m_valid;
    logic        m_err;
    logic [31:0] m_instr;

    function automatic bit bad_addr(input logic [63:0] a);
        return (a % 64'd4 != 64'd0) || (a / 64'd4 >= 64'd16);
    endfunction

    function automatic bit model_ready();
        return !load_en && (!m_valid || resp_ready);
    endfunction

    // Model state advances on each edge using the inputs held before it.
    always @(posedge clk) begin
        if (reset) begin
            m_count <= 0;
            m_valid <= 1'b0;
            m_err   <= 1'b0;
            m_instr <= 32'h0;
        end else begin
            if (load_en && m_count < 16) begin
                m_mem[m_count] <= load_data;
                m_count        <= m_count + 1;
            end
            if (req_valid && model_ready()) begin
                m_valid <= 1'b1;
                m_err   <= bad_addr(adr);
                m_instr <= bad_addr(adr) ? 32'h0000_0013 : m_mem[int'(adr / 64'd4)];
            end else if (resp_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("req_ready", req_ready, model_ready());
            chk("resp_valid", resp_valid, m_valid);
            chk("load_full", load_full, m_count == 16);
            if (m_valid) begin
                chk("resp_err", resp_err, m_err);
                chk("Instruction", Instruction, m_instr);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic le, input logic [31:0] ld, input logic rv,
                         input logic [63:0] a, input logic rr);
        load_en    = le;
        load_data  = ld;
        req_valid  = rv;
        adr        = a;
        resp_ready = rr;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [63:0] a);
        drive(1'b0, 32'h0, 1'b1, a, 1'b1);
        step();
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
        step();
    endtask

    logic [63:0] err_addrs [3];

    initial begin
        err_addrs[0] = 64'h6;
        err_addrs[1] = 64'd64;
        err_addrs[2] = 64'hFFFF_FFFF_FFFF_FFFC;

        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
        step();
        step();
        chk_on = 1'b1;
        chk("reset resp_valid", resp_valid, 1'b0);
        chk("reset resp_err", resp_err, 1'b0);
        chk("reset Instruction", Instruction, 32'h0);
        chk("reset load_full", load_full, 1'b0);
        chk("reset req_ready", req_ready, 1'b1);
        reset = 1'b0;

        // Program load of 16 words, then one ignored extra load.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'h1000_0000 + i, 1'b0, 64'h0, 1'b1);
            step();
            chk("load_full during load", load_full, i == 15);
        end
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 64'h0, 1'b1);
        step();
        chk("load_full after extra load", load_full, 1'b1);

        fetch(64'h0);
        chk("fetch 0 valid", resp_valid, 1'b1);
        chk("fetch 0 data", Instruction, 32'h1000_0000);
        idle();

        fetch(64'h8);
        chk("fetch 8 valid", resp_valid, 1'b1);
        chk("fetch 8 data", Instruction, 32'h1000_0002);
        chk("fetch 8 err", resp_err, 1'b0);
        idle();

        // Back-to-back streaming: one response per cycle, in order.
        for (int i = 0; i < 16; i++) begin
            fetch(64'(4 * i));
            chk("stream valid", resp_valid, 1'b1);
            chk("stream data", Instruction, 32'h1000_0000 + i);
        end
        idle();

        // Backpressure: held response must stay put while the next request waits.
        fetch(64'h4);
        drive(1'b0, 32'h0, 1'b1, 64'h8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("bp req_ready", req_ready, 1'b0);
            step();
            chk("bp hold data", Instruction, 32'h1000_0001);
            chk("bp hold valid", resp_valid, 1'b1);
        end
        drive(1'b0, 32'h0, 1'b1, 64'h8, 1'b1);
        chk("bp release ready", req_ready, 1'b1);
        step();
        chk("bp delivered", Instruction, 32'h1000_0002);
        idle();

        // Erroneous fetches return the NOP word with the error flag.
        for (int i = 0; i < 3; i++) begin
            fetch(err_addrs[i]);
            chk("err flag", resp_err, 1'b1);
            chk("err data", Instruction, 32'h0000_0013);
        end
        idle();

        // Load has priority over a simultaneous fetch request.
        drive(1'b1, 32'h5555_5555, 1'b1, 64'h0, 1'b1);
        chk("prio req_ready", req_ready, 1'b0);
        step();
        chk("prio no resp", resp_valid, 1'b0);

        // Reset with a pending response and a presented request.
        drive(1'b0, 32'h0, 1'b1, 64'h0, 1'b0);
        step();
        chk("pre-reset valid", resp_valid, 1'b1);
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 64'h4, 1'b1);
        step();
        chk("reset drops resp", resp_valid, 1'b0);
        chk("reset clears full", load_full, 1'b0);
        reset = 1'b0;
        fetch(64'hC);
        chk("retained data", Instruction, 32'h1000_0003);
        idle();

        // Randomized traffic; a stalled request keeps its address.
        for (int c = 0; c < 600; c++) begin
            logic        le;
            logic        rv;
            logic [63:0] a;
            int          k;
            if (req_valid && !model_ready()) begin
                rv = 1'b1;
                a  = adr;
            end else begin
                rv = ($urandom_range(0, 3) != 0);
                k  = $urandom_range(0, 9);
                if (k < 7)       a = 64'(4 * $urandom_range(0, 15));
                else if (k == 7) a = 64'($urandom_range(0, 63));
                else if (k == 8) a = 64'(4 * $urandom_range(16, 40));
                else             a = {$urandom, $urandom};
            end
            le = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 99) == 0);
            drive(le, $urandom, rv, a, ($urandom_range(0, 2) != 0));
            step();
        end
        reset = 1'b0;
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
